// File: rtl/freq_synth_pkg.sv
// Shared constants and types for the square-wave frequency synthesizer.
// Holds the default clock/width parameters and the control state encoding.
package freq_synth_pkg;

    localparam int CLK_HZ_DEFAULT = 50_000_000;
    localparam int DIV_W_DEFAULT  = 26;
    localparam int FREQ_W         = 16;
    localparam int DIVISOR_W      = FREQ_W + 1;
    localparam int HALF_PER_W     = DIV_W_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

endpackage

// File: rtl/freq_synth_half_period_div.sv
// Restoring divider producing one quotient bit per clock.
// The first bit is resolved on the start edge so done arrives DIV_W-1 cycles later.
module half_period_div
    import freq_synth_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic                 mclk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DIV_W-1:0]     dividend,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIV_W-1:0]     quotient,
    output logic                 done
);

    localparam int CNT_W = $clog2(DIV_W + 1);

    logic [DIVISOR_W-1:0] rem_q, rem_d, dsr_q, dsr_d, src_rem, src_dsr;
    logic [DIV_W-1:0]     quo_q, quo_d, src_quo;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 run_q, run_d;
    logic [DIVISOR_W:0]   rem_sh;
    logic                 fits;

    always_ff @(posedge mclk) begin
        if (rst) begin
            rem_q <= '0;
            dsr_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            dsr_q <= dsr_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    always_comb begin
        // A start restarts from fresh operands even if a division is in flight.
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        src_dsr = start ? divisor : dsr_q;
        rem_sh  = {src_rem, src_quo[DIV_W-1]};
        fits    = (rem_sh >= {1'b0, src_dsr});

        rem_d = rem_q;
        quo_d = quo_q;
        dsr_d = dsr_q;
        cnt_d = cnt_q;
        run_d = run_q;
        done  = 1'b0;

        if (start || (run_q && (cnt_q != '0))) begin
            rem_d = fits ? DIVISOR_W'(rem_sh - {1'b0, src_dsr}) : DIVISOR_W'(rem_sh);
            quo_d = {src_quo[DIV_W-2:0], fits};
            dsr_d = src_dsr;
        end

        if (start) begin
            cnt_d = CNT_W'(DIV_W - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                done  = 1'b1;
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/freq_synth.sv
// Programmable 50%-duty square-wave generator: half-period = CLK_HZ/(2*freq),
// computed by a serial divider while the previous waveform keeps running.
module freq_synth
    import freq_synth_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int DIV_W  = DIV_W_DEFAULT
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] freq,
    input  logic              load,
    output logic              sq_out,
    output logic              busy,
    output logic              active,
    output logic              edge_tick
);

    localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_HZ);

    state_e           state_q, state_d;
    logic             sq_q, sq_d, busy_q, busy_d, active_q, active_d, tick_q, tick_d;
    logic [DIV_W-1:0] half_per_q, half_per_d, cnt_q, cnt_d, quotient;
    logic             load_nz, load_zero, div_done, wrap;

    assign load_nz   = load && (freq != '0);
    assign load_zero = load && (freq == '0);

    half_period_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .mclk    (mclk),
        .rst     (rst),
        .start   (load_nz),
        .dividend(DIVIDEND),
        .divisor ({freq, 1'b0}),
        .quotient(quotient),
        .done    (div_done)
    );

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sq_q       <= 1'b0;
            busy_q     <= 1'b0;
            active_q   <= 1'b0;
            tick_q     <= 1'b0;
            half_per_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sq_q       <= sq_d;
            busy_q     <= busy_d;
            active_q   <= active_d;
            tick_q     <= tick_d;
            half_per_q <= half_per_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_zero) begin
            state_d = ST_IDLE;
        end else if (load_nz) begin
            state_d = ST_DIVIDE;
        end else if ((state_q == ST_DIVIDE) && div_done) begin
            state_d = ST_RUN;
        end
    end

    always_comb begin
        sq_d       = sq_q;
        cnt_d      = cnt_q;
        tick_d     = 1'b0;
        busy_d     = busy_q;
        active_d   = active_q;
        half_per_d = half_per_q;
        // >= rather than == so a shortened half-period wraps immediately.
        wrap       = (cnt_q >= (half_per_q - DIV_W'(1)));

        if (active_q) begin
            if (wrap) begin
                cnt_d  = '0;
                sq_d   = ~sq_q;
                tick_d = ~sq_q;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end

        if (load_zero) begin
            busy_d   = 1'b0;
            active_d = 1'b0;
            sq_d     = 1'b0;
            cnt_d    = '0;
            tick_d   = 1'b0;
        end else if (load_nz) begin
            busy_d = 1'b1;
        end else if ((state_q == ST_DIVIDE) && div_done) begin
            busy_d     = 1'b0;
            active_d   = 1'b1;
            half_per_d = (quotient == '0) ? DIV_W'(1) : quotient;
        end
    end

    always_comb begin
        sq_out    = sq_q;
        busy      = busy_q;
        active    = active_q;
        edge_tick = tick_q;
    end

endmodule

// File: tb/tb_freq_synth.sv
// Randomized and directed bench for freq_synth with a cycle-level behavioural
// model built from half-period arithmetic (CLK_HZ=1000, DIV_W=26).
module tb_freq_synth;

    localparam int CLK_HZ = 1000;
    localparam int DIV_W  = 26;

    logic        mclk = 1'b0;
    logic        rst  = 1'b1;
    logic        load = 1'b0;
    logic [15:0] freq = '0;
    logic        sq_out, busy, active, edge_tick;

    freq_synth #(
        .CLK_HZ(CLK_HZ),
        .DIV_W (DIV_W)
    ) dut (
        .mclk     (mclk),
        .rst      (rst),
        .freq     (freq),
        .load     (load),
        .sq_out   (sq_out),
        .busy     (busy),
        .active   (active),
        .edge_tick(edge_tick)
    );

    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt = 0;
    int tick_cnt = 0;

    // Model state: waveform level, edges since last toggle, current and pending half-period.
    int m_sq = 0, m_busy = 0, m_active = 0, m_tick = 0;
    int m_elapsed = 0, m_hp = 0, m_pending = 0, m_left = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_edge(input bit r, input bit l, input int f);
        if (r) begin
            m_sq = 0; m_busy = 0; m_active = 0; m_tick = 0;
            m_elapsed = 0; m_hp = 0; m_left = 0;
        end else begin
            m_tick = 0;
            if (m_active != 0) begin
                if (m_elapsed + 1 >= m_hp) begin
                    m_sq      = 1 - m_sq;
                    m_tick    = m_sq;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
            if (l && f == 0) begin
                m_busy = 0; m_active = 0; m_sq = 0; m_elapsed = 0; m_tick = 0;
            end else if (l) begin
                m_busy    = 1;
                m_left    = DIV_W;
                m_pending = CLK_HZ / (2 * f);
                if (m_pending < 1) m_pending = 1;
            end else if (m_busy != 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy   = 0;
                    m_active = 1;
                    m_hp     = m_pending;
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit l, input int f);
        rst  = r;
        load = l;
        freq = f[15:0];
        if (r) $display("txn rst load=%0d @%0t", l, $time);
        else if (l) $display("txn load freq=%0d @%0t", f, $time);
        @(posedge mclk);
        model_edge(r, l, f);
        #1;
        check_eq("sq_out", int'(sq_out), m_sq);
        check_eq("busy", int'(busy), m_busy);
        check_eq("active", int'(active), m_active);
        check_eq("edge_tick", int'(edge_tick), m_tick);
        if (busy) busy_cnt++;
        if (edge_tick) tick_cnt++;
        rst  = 1'b0;
        load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0);
    endtask

    initial begin
        int sel, fr, guard;

        repeat (3) cyc(1'b1, 1'b0, 0);
        check_eq("reset_outputs", int'({sq_out, busy, active, edge_tick}), 0);

        // Basic 100 Hz: 26 busy cycles, then 10-cycle period.
        busy_cnt = 0;
        cyc(1'b0, 1'b1, 100);
        idle(30);
        check_eq("busy_len_100", busy_cnt, 26);
        tick_cnt = 0;
        idle(100);
        check_eq("ticks_100", tick_cnt, 10);

        // Switch to 1 Hz while running; old period continues during the divide.
        cyc(1'b0, 1'b1, 1);
        idle(2100);

        // 600 Hz clamps to half-period 1.
        cyc(1'b0, 1'b1, 600);
        idle(30);
        tick_cnt = 0;
        idle(20);
        check_eq("ticks_600", tick_cnt, 10);

        // Stop: no edge ticks afterwards.
        cyc(1'b0, 1'b1, 0);
        tick_cnt = 0;
        idle(30);
        check_eq("ticks_after_stop", tick_cnt, 0);
        check_eq("active_after_stop", int'(active), 0);

        // Reload during divide: busy extends to 26 cycles after the second load.
        cyc(1'b0, 1'b1, 100);
        idle(9);
        busy_cnt = 0;
        cyc(1'b0, 1'b1, 50);
        idle(40);
        check_eq("busy_len_reload", busy_cnt, 26);
        tick_cnt = 0;
        idle(200);
        check_eq("ticks_50", tick_cnt, 10);

        // Reset mid-division, then immediate reload.
        cyc(1'b0, 1'b1, 100);
        idle(10);
        cyc(1'b1, 1'b0, 0);
        check_eq("rst_mid_div", int'({sq_out, busy, active, edge_tick}), 0);
        busy_cnt = 0;
        cyc(1'b0, 1'b1, 100);
        guard = 0;
        while (m_sq == 0 && guard < 100) begin
            cyc(1'b0, 1'b0, 0);
            guard++;
        end
        check_eq("high_phase_reached", m_sq, 1);
        check_eq("busy_len_after_rst", busy_cnt, 26);
        // Reset mid-high-phase, with a load that must be ignored.
        cyc(1'b1, 1'b1, 100);
        check_eq("rst_mid_high", int'({sq_out, busy, active, edge_tick}), 0);
        busy_cnt = 0;
        cyc(1'b0, 1'b1, 100);
        idle(30);
        check_eq("busy_len_rst2", busy_cnt, 26);
        tick_cnt = 0;
        idle(100);
        check_eq("ticks_rst2", tick_cnt, 10);

        // Randomized loads, aborts and resets.
        for (int t = 0; t < 400; t++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                cyc(1'b1, 1'b0, 0);
            end else if (sel < 12) begin
                case ($urandom_range(0, 3))
                    0: fr = 0;
                    1: fr = int'($urandom_range(1, 20));
                    2: fr = int'($urandom_range(21, 700));
                    default: fr = int'($urandom_range(0, 65535));
                endcase
                cyc(1'b0, 1'b1, fr);
                if ($urandom_range(0, 1) == 1) idle(30);
            end else begin
                cyc(1'b0, 1'b0, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/freq_synth.md
FREQ_SYNTH -- requirements
Module: freq_synth

Interface
REQ-001 Parameter CLK_HZ, default 50000000, mclk frequency in Hz; SHALL fit in DIV_W bits.
REQ-002 Parameter DIV_W, default 26, width of the dividend, quotient and half-period counter.
REQ-003 mclk  in  1  single clock; all logic SHALL be rising-edge mclk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 freq  in  16  requested output frequency in Hz, unsigned; sampled only when load=1.
REQ-006 load  in  1  one-cycle strobe; captures freq and starts a half-period computation.
REQ-007 sq_out  out  1  generated 50%-duty square wave.
REQ-008 busy  out  1  high while a half-period division is in progress.
REQ-009 active  out  1  high while sq_out is toggling (a nonzero frequency is programmed).
REQ-010 edge_tick  out  1  one-cycle pulse in the same cycle sq_out goes 0->1.

Function
REQ-011 States SHALL be IDLE (no frequency), DIVIDE (quotient pending) and RUN (toggling); DIVIDE SHALL keep the previous run/idle output behaviour.
REQ-012 load with freq!=0 in any state SHALL enter DIVIDE next cycle, discarding any division in progress.
REQ-013 load with freq=0 SHALL abort any division, and next cycle set busy=0, active=0, sq_out=0, counter=0 and enter IDLE.
REQ-014 Division SHALL compute Q = floor(CLK_HZ / (2*freq)), with a 17-bit divisor and a DIV_W-bit unsigned quotient, restoring, one quotient bit per cycle.
REQ-015 busy SHALL rise the cycle after load and stay high exactly DIV_W cycles; in the cycle busy falls, half_per SHALL be loaded with max(Q,1) and the state SHALL be RUN.
REQ-016 In RUN, a DIV_W-bit counter SHALL increment every cycle; when counter >= half_per-1, sq_out SHALL toggle and the counter SHALL clear in that cycle.
REQ-017 Output period SHALL therefore be 2*half_per mclk cycles, high and low halves each half_per cycles.
REQ-018 A new half_per loaded while already in RUN SHALL NOT clear sq_out or the counter; the >= compare SHALL make a shorter period take effect on the next cycle with no runt below 1 cycle.
REQ-019 The first toggle after IDLE->RUN SHALL drive sq_out 0->1, half_per cycles after busy falls.
REQ-020 edge_tick SHALL pulse only on 0->1 transitions of sq_out, never on 1->0 or in IDLE.
REQ-021 active SHALL be 1 exactly when state is RUN, or state is DIVIDE entered from RUN.
REQ-022 load together with rst SHALL be ignored; rst has priority.

Reset
REQ-023 rst SHALL set state=IDLE, sq_out=0, busy=0, active=0, edge_tick=0, half_per=0, counter=0 and clear the divider datapath, including mid-division and mid-period.
REQ-024 The first load SHALL be accepted in the first cycle after rst deasserts.

Structure
REQ-025 Shared package freq_synth_pkg SHALL hold the CLK_HZ and DIV_W defaults, the state enumeration and the half-period width constant.
REQ-026 The divider SHALL be sub-module half_period_div (start, dividend, divisor, quotient, done); the state machine, counter and outputs SHALL stay in freq_synth.
REQ-027 No combinational divide operator SHALL appear; target size is 120-400 RTL lines total.

Verification (CLK_HZ=1000, DIV_W=26 for all scenarios)
REQ-028 rst, then load freq=100 -> busy high 26 cycles; half_per=5; sq_out period 10 cycles, 5 high, 5 low; edge_tick once per 10 cycles.
REQ-029 freq=100 running, then load freq=1 -> sq_out keeps its 10-cycle period during busy, then switches to 1000-cycle period with no glitch.
REQ-030 load freq=600 -> Q=0 clamped to 1; sq_out toggles every cycle (period 2); edge_tick every 2 cycles.
REQ-031 running, then load freq=0 -> next cycle sq_out=0, active=0, busy=0; no edge_tick thereafter.
REQ-032 load freq=100, then load freq=50 10 cycles later -> busy stays high until 26 cycles after the second load; final half_per=10.
REQ-033 rst asserted mid-division and mid-high-phase -> all outputs 0 next cycle; load freq=100 in the first cycle after reset -> REQ-028 timing.
